// File: rtl/zigzag_decryption_nrail.sv
// Rail-fence (zigzag) decryptor for 2..MAX_KEY rails: buffers ciphertext until the
// start token, derives per-rail read pointers, then streams plaintext one char per clock.
module zigzag_decryption_nrail #(
    parameter int              D_WIDTH                = 8,
    parameter int              KEY_WIDTH              = 16,
    parameter int              MAX_NOF_CHARS          = 50,
    parameter int              MAX_KEY                = 8,
    parameter logic [7:0]      START_DECRYPTION_TOKEN = 8'hFA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o
);

    localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam int RW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;

    localparam logic [KEY_WIDTH-1:0] ONE   = KEY_WIDTH'(1);
    localparam logic [KEY_WIDTH-1:0] TWO   = KEY_WIDTH'(2);
    localparam logic [KEY_WIDTH-1:0] MAXK  = KEY_WIDTH'(MAX_KEY);
    localparam logic [KEY_WIDTH-1:0] MAXN  = KEY_WIDTH'(MAX_NOF_CHARS);
    localparam logic [D_WIDTH-1:0]   TOKEN = D_WIDTH'(START_DECRYPTION_TOKEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        OFFS = 2'd2,
        EMIT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [D_WIDTH-1:0]   mem [MAX_NOF_CHARS];
    logic [KEY_WIDTH-1:0] ptr [MAX_KEY];

    logic [KEY_WIDTH-1:0] n;        // characters buffered for the current message
    logic [KEY_WIDTH-1:0] k;        // rail count latched at the token
    logic [KEY_WIDTH-1:0] cyc;      // zigzag period 2*(k-1)
    logic [KEY_WIDTH-1:0] full;     // complete periods in the message
    logic [KEY_WIDTH-1:0] rem;      // characters in the trailing partial period
    logic [KEY_WIDTH-1:0] acc;      // running start offset while filling ptr[]
    logic [KEY_WIDTH-1:0] rail;
    logic [KEY_WIDTH-1:0] cnt;      // characters emitted so far
    logic                 down;     // zigzag direction: 1 = towards rail k-1
    logic                 pass;     // key unusable for zigzag: emit buffer in order

    logic                 is_token;
    logic                 pass_sel;
    logic [KEY_WIDTH-1:0] rail_len;
    logic [KEY_WIDTH-1:0] rail_step;
    logic                 down_step;
    logic [RW-1:0]        rail_idx;
    logic [KEY_WIDTH-1:0] rd_ptr;
    logic [AW-1:0]        rd_addr;

    assign is_token = valid_i && (data_i == TOKEN);
    assign pass_sel = (key < TWO) || (key > MAXK) || (key >= n);
    assign rail_idx = rail[RW-1:0];
    assign rd_ptr   = ptr[rail_idx];
    assign rd_addr  = pass ? cnt[AW-1:0] : rd_ptr[AW-1:0];

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (is_token) state_next = pass_sel ? EMIT : DIV;
            DIV:  if (rem < cyc) state_next = OFFS;
            OFFS: if (rail == k - ONE) state_next = EMIT;
            EMIT: if (cnt == n) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Number of ciphertext characters that landed on the current rail.
    always_comb begin
        rail_len = full;
        if (rail == '0) begin
            rail_len = full + KEY_WIDTH'(rem != '0);
        end else if (rail == k - ONE) begin
            rail_len = full + KEY_WIDTH'(rem > k - ONE);
        end else begin
            rail_len = (full << 1) + KEY_WIDTH'(rem > rail) + KEY_WIDTH'(rem > cyc - rail);
        end
    end

    // Zigzag walk 0,1..k-1,k-2..1,0,1...
    always_comb begin
        rail_step = rail;
        down_step = down;
        if (down) begin
            if (rail == k - ONE) begin
                rail_step = rail - ONE;
                down_step = 1'b0;
            end else begin
                rail_step = rail + ONE;
            end
        end else begin
            if (rail == '0) begin
                rail_step = ONE;
                down_step = 1'b1;
            end else begin
                rail_step = rail - ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: the character buffer is reset here because a cleared buffer is part of the
    // reset state; a buffer that never needs clearing would be left out of the reset branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            n       <= '0;
            k       <= '0;
            cyc     <= '0;
            full    <= '0;
            rem     <= '0;
            acc     <= '0;
            rail    <= '0;
            cnt     <= '0;
            down    <= 1'b1;
            pass    <= 1'b0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) mem[i] <= '0;
            for (int i = 0; i < MAX_KEY; i++) ptr[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    busy    <= 1'b0;
                    if (is_token) begin
                        busy <= 1'b1;
                        k    <= key;
                        cyc  <= (key - ONE) << 1;
                        rem  <= n;
                        full <= '0;
                        acc  <= '0;
                        rail <= '0;
                        cnt  <= '0;
                        down <= 1'b1;
                        pass <= pass_sel;
                    end else if (valid_i && (n != MAXN)) begin
                        mem[n[AW-1:0]] <= data_i;
                        n              <= n + ONE;
                    end
                end

                // One subtraction per clock yields full = n / cyc, rem = n % cyc.
                DIV: begin
                    if (rem >= cyc) begin
                        rem  <= rem - cyc;
                        full <= full + ONE;
                    end
                end

                OFFS: begin
                    ptr[rail_idx] <= acc;
                    acc           <= acc + rail_len;
                    if (rail == k - ONE) begin
                        rail <= '0;
                        down <= 1'b1;
                    end else begin
                        rail <= rail + ONE;
                    end
                end

                EMIT: begin
                    if (cnt == n) begin
                        valid_o <= 1'b0;
                        data_o  <= '0;
                        busy    <= 1'b0;
                        n       <= '0;
                    end else begin
                        valid_o <= 1'b1;
                        data_o  <= mem[rd_addr];
                        cnt     <= cnt + ONE;
                        if (!pass) begin
                            ptr[rail_idx] <= rd_ptr + ONE;
                            rail          <= rail_step;
                            down          <= down_step;
                        end
                    end
                end

                default: begin
                    valid_o <= 1'b0;
                    data_o  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zigzag_decryption_nrail.sv
// Directed bench for zigzag_decryption_nrail: hand-computed ciphertexts plus a
// rail-fence encryption model for the full-size message.
module tb_zigzag_decryption_nrail;

    localparam logic [7:0] TOK = 8'hFA;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic [15:0] key = '0;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] msg_q [$];
    logic [7:0] exp_q [$];

    zigzag_decryption_nrail dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key     (key),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic put(input logic [7:0] c, input logic [15:0] k);
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = c;
        key     = k;
    endtask

    task automatic send(input logic [15:0] k);
        foreach (msg_q[i]) put(msg_q[i], k);
        put(TOK, k);
    endtask

    task automatic load_msg(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic load_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // Quiet inputs, or garbage (chars, tokens, key changes) that a busy DUT must ignore.
    task automatic drive_idle(input bit noise, input int i);
        if (noise) begin
            valid_i = 1'b1;
            data_i  = (i % 3 == 0) ? TOK : 8'(8'h41 + i);
            key     = 16'(i % 9);
        end else begin
            valid_i = 1'b0;
            data_i  = '0;
        end
    endtask

    task automatic collect(input string tag, input bit noise);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            drive_idle(noise, waited);
            if (valid_o === 1'b1) seen = 1'b1;
            else waited++;
        end
        check({tag, " first valid_o"}, 16'(seen), 16'd1);
        if (seen) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    drive_idle(noise, i);
                end
                check({tag, " valid_o"}, 16'(valid_o), 16'd1);
                check({tag, " data_o"}, 16'(data_o), 16'(exp_q[i]));
                if (i == 0) check({tag, " busy"}, 16'(busy), 16'd1);
            end
            @(negedge clk);
            drive_idle(1'b0, 0);
            check({tag, " done valid_o"}, 16'(valid_o), 16'd0);
            check({tag, " done busy"}, 16'(busy), 16'd0);
            check({tag, " done data_o"}, 16'(data_o), 16'd0);
        end
    endtask

    initial begin
        int waited;
        int m;
        int rr;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 16'(busy), 16'd0);
        check("reset valid_o", 16'(valid_o), 16'd0);
        check("reset data_o", 16'(data_o), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // key=3
        load_msg("AEBDFCG"); load_exp("ABCDEFG");
        send(16'd3);
        collect("k3", 1'b0);

        // key=2, odd length
        load_msg("ACEBD"); load_exp("ABCDE");
        send(16'd2);
        collect("k2", 1'b0);

        // key=4 with chars, tokens and key changes hammered in while busy
        load_msg("AGBFHCEIDJ"); load_exp("ABCDEFGHIJ");
        send(16'd4);
        collect("k4 noisy", 1'b1);

        // Pass-through: key below 2 and key >= n
        load_msg("XYZ"); load_exp("XYZ");
        send(16'd1);
        collect("k1 pass", 1'b0);

        load_msg("ABC"); load_exp("ABC");
        send(16'd5);
        collect("k5 pass", 1'b0);

        // Empty message: busy for exactly one cycle
        put(TOK, 16'd3);
        @(negedge clk);
        drive_idle(1'b0, 0);
        check("empty busy up", 16'(busy), 16'd1);
        check("empty valid_o", 16'(valid_o), 16'd0);
        @(negedge clk);
        check("empty busy down", 16'(busy), 16'd0);
        check("empty valid_o after", 16'(valid_o), 16'd0);

        // key=MAX_KEY, n=MAX_NOF_CHARS, plus a 51st char that must be dropped
        exp_q.delete();
        msg_q.delete();
        for (int i = 0; i < 50; i++) exp_q.push_back(8'(8'h21 + i));
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 50; i++) begin
                m  = i % 14;
                rr = (m < 8) ? m : 14 - m;
                if (rr == r) msg_q.push_back(exp_q[i]);
            end
        end
        msg_q.push_back(8'h99);
        send(16'd8);
        collect("k8 full", 1'b0);

        // Reset in the middle of output
        load_msg("AEBDFCG");
        send(16'd3);
        waited = 0;
        @(negedge clk);
        drive_idle(1'b0, 0);
        while (valid_o !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("midrst reached emit", 16'(valid_o), 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst busy", 16'(busy), 16'd0);
        check("midrst valid_o", 16'(valid_o), 16'd0);
        check("midrst data_o", 16'(data_o), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_msg("ACEBD"); load_exp("ABCDE");
        send(16'd2);
        collect("after rst k2", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
